// File: rtl/fpu_issue_sequencer.sv
// Multi-cycle issue controller for the FP datapath: accepts an FP R-type op,
// stalls the core for the unit latency, then pulses a writeback or FPcond load.
module fpu_issue_sequencer #(
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_DIV = 8,
  parameter int unsigned LAT_CMP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [5:0]  req_funct,
  input  logic [4:0]  req_fd,
  input  logic        flush,
  output logic        req_ready,
  output logic        stall,
  output logic        opnd_latch,
  output logic [2:0]  op_sel,
  output logic        wb_en,
  output logic [4:0]  wb_fd,
  output logic        cond_we,
  output logic        illegal,
  output logic [15:0] stall_cnt
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SCNT_W = 16;
  localparam logic [2:0] OP_CMP = 3'd4;

  if (LAT_ADD < 1 || LAT_ADD > 15 || LAT_MUL < 1 || LAT_MUL > 15 ||
      LAT_DIV < 1 || LAT_DIV > 15 || LAT_CMP < 1 || LAT_CMP > 15) begin : g_lat_check
    $error("fpu_issue_sequencer: every LAT_* parameter must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          fd_q, fd_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;

  logic                dec_ok;
  logic [2:0]          dec_op;
  logic [CNT_W-1:0]    dec_lat;

  // Funct decode: unit select and the counter preload (latency - 1)
  always_comb begin
    dec_ok  = 1'b1;
    dec_op  = 3'd0;
    dec_lat = '0;
    unique case (req_funct)
      6'h00:   begin dec_op = 3'd0;   dec_lat = CNT_W'(LAT_ADD - 1); end
      6'h01:   begin dec_op = 3'd1;   dec_lat = CNT_W'(LAT_ADD - 1); end
      6'h02:   begin dec_op = 3'd2;   dec_lat = CNT_W'(LAT_MUL - 1); end
      6'h03:   begin dec_op = 3'd3;   dec_lat = CNT_W'(LAT_DIV - 1); end
      6'h32:   begin dec_op = OP_CMP; dec_lat = CNT_W'(LAT_CMP - 1); end
      default: dec_ok = 1'b0;
    endcase
  end

  // Next state and outputs; flush wins in every state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    fd_d       = fd_q;
    scnt_d     = scnt_q;
    req_ready  = 1'b0;
    stall      = 1'b0;
    opnd_latch = 1'b0;
    wb_en      = 1'b0;
    cond_we    = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          if (dec_ok) begin
            stall      = 1'b1;
            opnd_latch = 1'b1;
            op_d       = dec_op;
            fd_d       = req_fd;
            cnt_d      = dec_lat;
            state_d    = EXEC;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      EXEC: begin
        stall = 1'b1;
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        if (!flush) begin
          wb_en   = (op_q != OP_CMP);
          cond_we = (op_q == OP_CMP);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      req_ready  = 1'b0;
      stall      = 1'b0;
      opnd_latch = 1'b0;
      wb_en      = 1'b0;
      cond_we    = 1'b0;
      illegal    = 1'b0;
    end

    if (stall && (scnt_q != {SCNT_W{1'b1}})) begin
      scnt_d = scnt_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      fd_q    <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fd_q    <= fd_d;
      scnt_q  <= scnt_d;
    end
  end

  assign op_sel    = op_q;
  assign wb_fd     = fd_q;
  assign stall_cnt = scnt_q;

endmodule

// File: doc/fpu_issue_sequencer.md
# fpu_issue_sequencer

Multi-cycle issue controller for the floating-point datapath of the MIPS core. It accepts decoded FP R-type operations (add.s, sub.s, mul.s, div.s, c.eq.s), stalls the core for a per-operation latency while the selected FP unit settles, then issues a one-cycle writeback to the FP register file or the FP condition flag. It sits between instruction decode and the FP register file / FPcond flop, and lets slow units such as the divider close timing without slowing integer instructions.

## Interface
Parameters:
- LAT_ADD, 2: execute cycles for add.s and sub.s (1..15)
- LAT_MUL, 3: execute cycles for mul.s (1..15)
- LAT_DIV, 8: execute cycles for div.s (1..15)
- LAT_CMP, 1: execute cycles for c.eq.s (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  decode holds an FP R-type instruction (opcode 0x11, fmt 0x10)
- req_funct  in  6  IR[5:0]: 0x00 add, 0x01 sub, 0x02 mul, 0x03 div, 0x32 c.eq
- req_fd  in  5  destination FP register, IR[10:6]
- flush  in  1  abort the in-flight operation
- req_ready  out  1  sequencer is IDLE and can accept
- stall  out  1  hold PC and all architectural state
- opnd_latch  out  1  one-cycle pulse: capture Fs/Ft into the FP operand registers
- op_sel  out  3  unit select: 0 add, 1 sub, 2 mul, 3 div, 4 cmp
- wb_en  out  1  one-cycle pulse: write FP result to register wb_fd
- wb_fd  out  5  latched destination register
- cond_we  out  1  one-cycle pulse: load the FPcond flop from the comparator aeqb
- illegal  out  1  one-cycle pulse: unsupported funct presented
- stall_cnt  out  16  saturating count of stalled cycles since reset

## Operation
- States: IDLE, EXEC, WB.
- IDLE: req_ready=1. If req_valid and funct is supported: opnd_latch=1 and stall=1 combinationally; op_sel, wb_fd, and the op class are latched; the counter loads LAT-1 for the class; next state is EXEC.
- Unsupported funct with req_valid in IDLE: illegal=1 for that cycle, no stall, stay IDLE.
- EXEC: stall=1, req_ready=0, op_sel holds the latched value. The counter decrements each cycle. At counter==0 the next state is WB.
- WB: stall=0 so the core retires the instruction at this edge; req_ready=0, so the still-present req_valid is not re-accepted.
  - Arithmetic ops: wb_en=1.
  - c.eq: cond_we=1 and wb_en=0.
  - Next state is IDLE.
- flush: has priority in every state. Next state is IDLE; wb_en and cond_we are 0 in the flush cycle; no opnd_latch in the flush cycle.
- stall_cnt increments on each cycle with stall=1 and saturates at 0xFFFF.
- Simultaneous flush and req_valid in IDLE: the request is ignored.

## Timing
- Reset (rst_n=0 at an edge): state becomes IDLE, counter 0, op_sel 0, wb_fd 0, stall_cnt 0.
- While rst_n=0: stall, opnd_latch, wb_en, cond_we, illegal and req_ready are all forced to 0.
- Reset mid-EXEC: the operation is dropped with no writeback.
- Acceptance cycle T0 is in IDLE. EXEC occupies T1..T(L). WB is at T(L+1).
- Stalled cycles per operation: L+1 (T0..TL). The instruction retires at the end of T(L+1).
- Back-to-back FP operations: the second is accepted at T(L+2), so the minimum spacing is L+2 cycles.
- opnd_latch, wb_en, cond_we and illegal are never high for more than one consecutive cycle.
- Parameter value 0 is illegal; the bench checks that it is flagged at elaboration.

## Test plan
- Reset with req_valid=1, funct 0x00 -> all pulse outputs 0 and stall_cnt=0 during reset. After release, accept in the first cycle.
- add.s (funct 0x00, fd=5), LAT_ADD=2 -> stall high for 3 cycles, opnd_latch at T0, op_sel=0; wb_en=1 with wb_fd=5 at T3; stall_cnt=3.
- div.s (funct 0x03, fd=31), LAT_DIV=8 -> 9 stall cycles, op_sel=3 through T8, wb_en at T9. A second mul.s held valid from T10 is accepted at T10.
- c.eq.s (funct 0x32), LAT_CMP=1 -> stall for 2 cycles, cond_we=1 at T2, wb_en stays 0.
- Illegal funct 0x07 -> illegal pulses once, stall=0, state stays IDLE. Next cycle add.s is accepted normally.
- div.s flushed at T4 -> IDLE at T5 with no wb_en/cond_we. stall_cnt=5. A new request is accepted at T5.
